flipper_bank: RTL and testbench
===============================

FLIPPER_BANK -- requirements
Module: flipper_bank

Interface
REQ-001 SHALL have parameter NUM_FLIPPERS, default 2: number of independent flippers, legal range 1..8.
REQ-002 SHALL have parameter FLIPPER_WIDTH_X, default 64: flipper width in pixels.
REQ-003 SHALL have parameter FLIPPER_HEIGHT_Y, default 8: flipper height in pixels.
REQ-004 SHALL have parameter BASE_X, default 160: rest topLeftX of flipper 0.
REQ-005 SHALL have parameter PITCH_X, default 256: rest-X spacing between flipper n and n+1.
REQ-006 SHALL have parameter TOP_Y, default 440: topLeftY of all flippers.
REQ-007 SHALL have parameter TRAVEL_PX, default 32: maximum offset from rest X.
REQ-008 SHALL have parameter STEP_PX, default 4: offset change per frame while moving; TRAVEL_PX SHALL be a multiple of STEP_PX.
REQ-009 SHALL have parameter HOLD_FRAMES, default 30: frame limit of the HOLD state.
REQ-010 SHALL have parameter FLIPPER_COLOR, default 8'hE0: 8-bit RGB of every flipper pixel.
REQ-011 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-012 SHALL have port resetN, input, 1 bit: reset, synchronous, active-low.
REQ-013 SHALL have ports pixelX and pixelY, input, 11 bits each: current scan pixel.
REQ-014 SHALL have port startOfFrame, input, 1 bit: one-cycle frame tick.
REQ-015 SHALL have ports pause and reset_level, input, 1 bit each: freeze motion; return all flippers to rest.
REQ-016 SHALL have port keyPressed, input, NUM_FLIPPERS bits: bit n commands flipper n.
REQ-017 SHALL have ports RGB_flipper (output, 8 bits) and drawFlipper (output, 1 bit): pixel colour and coverage.
REQ-018 SHALL have port hitIndex, output, 3 bits: index of the flipper covering the pixel.
REQ-019 SHALL have port speedX, output, 32 bits signed: X velocity in pixels/frame of the flipper covering the pixel.

Function
REQ-020 Each flipper SHALL own a 4-state FSM: IDLE, EXTEND, HOLD, RETRACT; offset is unsigned, range 0..TRAVEL_PX.
REQ-021 FSM and offset SHALL update only on clocks where startOfFrame=1 and pause=0; keyPressed is sampled on those clocks only.
REQ-022 IDLE: key=1 -> EXTEND; otherwise stay, offset=0.
REQ-023 EXTEND: offset += STEP_PX; key=0 -> RETRACT; offset reaching TRAVEL_PX -> HOLD; never exceeds TRAVEL_PX.
REQ-024 HOLD: frame counter counts frames; key=0 or count = HOLD_FRAMES-1 -> RETRACT; counter clears on entry.
REQ-025 RETRACT: offset -= STEP_PX; key=1 -> EXTEND; offset reaching 0 -> IDLE; never below 0.
REQ-026 Even-index flippers SHALL move right (X = rest + offset); odd-index flippers SHALL move left (X = rest - offset).
REQ-027 Coverage: pixelX in [X, X+FLIPPER_WIDTH_X) and pixelY in [TOP_Y, TOP_Y+FLIPPER_HEIGHT_Y), unsigned 11-bit compare.
REQ-028 On overlap of several flippers, the lowest index SHALL win for hitIndex and speedX.
REQ-029 drawFlipper, RGB_flipper, hitIndex, speedX SHALL be registered: one clock latency from pixelX/pixelY.
REQ-030 When not covered: drawFlipper=0, RGB_flipper=0, hitIndex=0, speedX=0; when covered, RGB_flipper=FLIPPER_COLOR.
REQ-031 speedX SHALL be +STEP_PX for right-moving EXTEND or left-moving RETRACT, -STEP_PX for the converse, 0 in IDLE/HOLD or when pause=1.
REQ-032 reset_level=1 SHALL force all FSMs to IDLE, offsets and counters to 0 on that clock, overriding pause and startOfFrame.
REQ-033 Drawing SHALL continue unchanged while pause=1.

Reset
REQ-034 resetN=0 at a rising clk edge SHALL set all FSMs to IDLE, offsets and counters to 0, and all outputs to 0.
REQ-035 Reset asserted mid-motion SHALL take priority over every other input on that clock.

Configuration
REQ-036 Macro FLIPPER_BANK_HOLD_EN: when defined, HOLD behaves per REQ-024; when undefined, HOLD does not exist and EXTEND reaching TRAVEL_PX goes directly to RETRACT.

Verification
REQ-037 Defaults, key[0] held 10 frames -> offset 4,8,..,32 after 8 frames, HOLD; pixel (200,444) gives drawFlipper=1, speedX=0 one clock later.
REQ-038 key[1] pressed 3 frames then released -> offset 12, RETRACT; next frame pixel inside flipper 1 gives speedX=+4, offset 8.
REQ-039 key[0] held with HOLD_EN defined -> RETRACT after exactly 30 HOLD frames; without the macro, RETRACT follows the frame where offset hits 32.
REQ-040 pause=1 during EXTEND for 5 frames -> offset constant, speedX=0, drawing active; pause=0 resumes +4/frame.
REQ-041 reset_level=1 with both flippers at offset 32 -> offsets 0, IDLE next clock; resetN=0 mid-EXTEND -> all outputs 0 next clock.

Source files
------------

// File: rtl/flipper_bank.sv
// flipper_bank: bank of sliding flippers, each with its own motion FSM, plus a registered pixel renderer.
// Optional feature macro FLIPPER_BANK_HOLD_EN adds a timed HOLD phase at full travel.
module flipper_bank #(
    parameter int          NUM_FLIPPERS     = 2,
    parameter int          FLIPPER_WIDTH_X  = 64,
    parameter int          FLIPPER_HEIGHT_Y = 8,
    parameter int          BASE_X           = 160,
    parameter int          PITCH_X          = 256,
    parameter int          TOP_Y            = 440,
    parameter int          TRAVEL_PX        = 32,
    parameter int          STEP_PX          = 4,
    parameter int          HOLD_FRAMES      = 30,
    parameter logic [7:0]  FLIPPER_COLOR    = 8'hE0
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic [10:0]             pixelX,
    input  logic [10:0]             pixelY,
    input  logic                    startOfFrame,
    input  logic                    pause,
    input  logic                    reset_level,
    input  logic [NUM_FLIPPERS-1:0] keyPressed,
    output logic [7:0]              RGB_flipper,
    output logic                    drawFlipper,
    output logic [2:0]              hitIndex,
    output logic signed [31:0]      speedX
);

    localparam int unsigned OFS_W = $clog2(TRAVEL_PX + 1);
    localparam logic [OFS_W-1:0] TRAVEL = OFS_W'(TRAVEL_PX);
    localparam logic [OFS_W-1:0] STEP   = OFS_W'(STEP_PX);

    // Elaboration-time parameter sanity checks.
    if (NUM_FLIPPERS < 1 || NUM_FLIPPERS > 8) begin : g_bad_num
        $error("flipper_bank: NUM_FLIPPERS must be 1..8");
    end
    if (STEP_PX < 1 || TRAVEL_PX < STEP_PX || (TRAVEL_PX % STEP_PX) != 0) begin : g_bad_step
        $error("flipper_bank: TRAVEL_PX must be a positive multiple of STEP_PX");
    end
    if (HOLD_FRAMES < 1) begin : g_bad_hold
        $error("flipper_bank: HOLD_FRAMES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXTEND  = 2'd1,
        HOLD    = 2'd2,
        RETRACT = 2'd3
    } state_t;

    state_t           state_q  [NUM_FLIPPERS];
    state_t           state_d  [NUM_FLIPPERS];
    logic [OFS_W-1:0] offset_q [NUM_FLIPPERS];
    logic [OFS_W-1:0] offset_d [NUM_FLIPPERS];

`ifdef FLIPPER_BANK_HOLD_EN
    localparam int unsigned CNT_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_FRAMES - 1);
    logic [CNT_W-1:0] cnt_q [NUM_FLIPPERS];
    logic [CNT_W-1:0] cnt_d [NUM_FLIPPERS];
`endif

    logic               draw_q, draw_d;
    logic [7:0]         rgb_q, rgb_d;
    logic [2:0]         hit_q, hit_d;
    logic signed [31:0] speed_q, speed_d;
    logic               y_hit;
    logic [10:0]        x_left;
    logic [11:0]        x_end;

    // Signed velocity of one flipper; even flippers extend rightwards, odd ones leftwards.
    function automatic logic signed [31:0] speed_of(input logic odd, input state_t st);
        logic signed [31:0] s;
        s = '0;
        if (st == EXTEND) begin
            s = odd ? -STEP_PX : STEP_PX;
        end else if (st == RETRACT) begin
            s = odd ? STEP_PX : -STEP_PX;
        end
        return s;
    endfunction

    // Per-flipper motion FSM, advanced once per unpaused frame.
    always_comb begin
        for (int n = 0; n < NUM_FLIPPERS; n++) begin
            state_d[n]  = state_q[n];
            offset_d[n] = offset_q[n];
`ifdef FLIPPER_BANK_HOLD_EN
            cnt_d[n]    = cnt_q[n];
`endif
            if (reset_level) begin
                state_d[n]  = IDLE;
                offset_d[n] = '0;
`ifdef FLIPPER_BANK_HOLD_EN
                cnt_d[n]    = '0;
`endif
            end else if (startOfFrame && !pause) begin
                case (state_q[n])
                    IDLE: begin
                        if (keyPressed[n]) begin
                            state_d[n]  = EXTEND;
                            offset_d[n] = STEP;
                        end
                    end
                    EXTEND: begin
                        if (!keyPressed[n]) begin
                            state_d[n] = RETRACT;
                        end else if (offset_q[n] >= TRAVEL - STEP) begin
                            offset_d[n] = TRAVEL;
`ifdef FLIPPER_BANK_HOLD_EN
                            state_d[n]  = HOLD;
                            cnt_d[n]    = '0;
`else
                            state_d[n]  = RETRACT;
`endif
                        end else begin
                            offset_d[n] = offset_q[n] + STEP;
                        end
                    end
`ifdef FLIPPER_BANK_HOLD_EN
                    HOLD: begin
                        if (!keyPressed[n] || cnt_q[n] == CNT_LAST) begin
                            state_d[n] = RETRACT;
                        end else begin
                            cnt_d[n] = cnt_q[n] + 1'b1;
                        end
                    end
`endif
                    RETRACT: begin
                        if (keyPressed[n]) begin
                            state_d[n] = EXTEND;
                        end else if (offset_q[n] <= STEP) begin
                            offset_d[n] = '0;
                            state_d[n]  = IDLE;
                        end else begin
                            offset_d[n] = offset_q[n] - STEP;
                        end
                    end
                    default: state_d[n] = IDLE;
                endcase
            end
        end
    end

    // Pixel coverage; scanning from the top index down lets the lowest index win on overlap.
    always_comb begin
        draw_d  = 1'b0;
        rgb_d   = '0;
        hit_d   = '0;
        speed_d = '0;
        x_left  = '0;
        x_end   = '0;
        y_hit   = (pixelY >= 11'(TOP_Y)) && ({1'b0, pixelY} < 12'(TOP_Y + FLIPPER_HEIGHT_Y));
        for (int n = NUM_FLIPPERS - 1; n >= 0; n--) begin
            if ((n % 2) == 0) begin
                x_left = 11'(BASE_X + n * PITCH_X + 32'(offset_q[n]));
            end else begin
                x_left = 11'(BASE_X + n * PITCH_X - 32'(offset_q[n]));
            end
            x_end = {1'b0, x_left} + 12'(FLIPPER_WIDTH_X);
            if (y_hit && pixelX >= x_left && {1'b0, pixelX} < x_end) begin
                draw_d  = 1'b1;
                rgb_d   = FLIPPER_COLOR;
                hit_d   = 3'(n);
                speed_d = pause ? '0 : speed_of((n % 2) == 1, state_q[n]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int n = 0; n < NUM_FLIPPERS; n++) begin
                state_q[n]  <= IDLE;
                offset_q[n] <= '0;
`ifdef FLIPPER_BANK_HOLD_EN
                cnt_q[n]    <= '0;
`endif
            end
            draw_q  <= 1'b0;
            rgb_q   <= '0;
            hit_q   <= '0;
            speed_q <= '0;
        end else begin
            for (int n = 0; n < NUM_FLIPPERS; n++) begin
                state_q[n]  <= state_d[n];
                offset_q[n] <= offset_d[n];
`ifdef FLIPPER_BANK_HOLD_EN
                cnt_q[n]    <= cnt_d[n];
`endif
            end
            draw_q  <= draw_d;
            rgb_q   <= rgb_d;
            hit_q   <= hit_d;
            speed_q <= speed_d;
        end
    end

    assign drawFlipper = draw_q;
    assign RGB_flipper = rgb_q;
    assign hitIndex    = hit_q;
    assign speedX      = speed_q;

endmodule

// File: tb/tb_flipper_bank.sv
// Self-checking bench for flipper_bank with default parameters; expectations adapt to FLIPPER_BANK_HOLD_EN.
`timescale 1ns/1ps
module tb_flipper_bank;

    localparam int NF    = 2;
    localparam int BASE  = 160;
    localparam int PITCH = 256;
    localparam int WID   = 64;
    localparam int TOPY  = 440;
    localparam int HGT   = 8;
    localparam int TRAV  = 32;
    localparam int STEP  = 4;
    localparam int HOLDF = 30;
    localparam logic [7:0] COLOR = 8'hE0;

    localparam int S_IDLE = 0;
    localparam int S_EXT  = 1;
    localparam int S_HOLD = 2;
    localparam int S_RET  = 3;

    logic               clk = 1'b0;
    logic               resetN = 1'b0;
    logic [10:0]        pixelX = '0;
    logic [10:0]        pixelY = '0;
    logic               startOfFrame = 1'b0;
    logic               pause = 1'b0;
    logic               reset_level = 1'b0;
    logic [NF-1:0]      keyPressed = '0;
    logic [7:0]         RGB_flipper;
    logic               drawFlipper;
    logic [2:0]         hitIndex;
    logic signed [31:0] speedX;

    flipper_bank dut (
        .clk          (clk),
        .resetN       (resetN),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .startOfFrame (startOfFrame),
        .pause        (pause),
        .reset_level  (reset_level),
        .keyPressed   (keyPressed),
        .RGB_flipper  (RGB_flipper),
        .drawFlipper  (drawFlipper),
        .hitIndex     (hitIndex),
        .speedX       (speedX)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic               draw;
        logic [7:0]         rgb;
        logic [2:0]         hit;
        logic signed [31:0] spd;
    } out_t;

    typedef struct {
        int   px;
        int   py;
        logic draw;
        int   hit;
    } vec_t;

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_st  [NF];
    int   m_ofs [NF];
    int   m_cnt [NF];

    // Reference output for the current inputs and model state (what the DUT registers at the next edge).
    function automatic out_t model_out();
        out_t r;
        bit   found;
        int   x;
        r = '0;
        found = 1'b0;
        if (!resetN) return r;
        for (int i = 0; i < NF; i++) begin
            x = (i % 2 == 0) ? BASE + i * PITCH + m_ofs[i] : BASE + i * PITCH - m_ofs[i];
            if (!found && int'(pixelX) >= x && int'(pixelX) < x + WID &&
                int'(pixelY) >= TOPY && int'(pixelY) < TOPY + HGT) begin
                found = 1'b1;
                r.draw = 1'b1;
                r.rgb  = COLOR;
                r.hit  = 3'(i);
                if (pause)                r.spd = 0;
                else if (m_st[i] == S_EXT) r.spd = (i % 2 == 0) ? STEP : -STEP;
                else if (m_st[i] == S_RET) r.spd = (i % 2 == 0) ? -STEP : STEP;
                else                       r.spd = 0;
            end
        end
        return r;
    endfunction

    // Reference motion model, applied at each rising edge.
    task automatic model_step();
        for (int i = 0; i < NF; i++) begin
            if (!resetN || reset_level) begin
                m_st[i] = S_IDLE; m_ofs[i] = 0; m_cnt[i] = 0;
            end else if (startOfFrame && !pause) begin
                case (m_st[i])
                    S_IDLE: if (keyPressed[i]) begin m_st[i] = S_EXT; m_ofs[i] = STEP; end
                    S_EXT: begin
                        if (!keyPressed[i]) m_st[i] = S_RET;
                        else begin
                            m_ofs[i] = m_ofs[i] + STEP;
                            if (m_ofs[i] >= TRAV) begin
                                m_ofs[i] = TRAV;
`ifdef FLIPPER_BANK_HOLD_EN
                                m_st[i] = S_HOLD; m_cnt[i] = 0;
`else
                                m_st[i] = S_RET;
`endif
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!keyPressed[i] || m_cnt[i] == HOLDF - 1) m_st[i] = S_RET;
                        else m_cnt[i] = m_cnt[i] + 1;
                    end
                    default: begin
                        if (keyPressed[i]) m_st[i] = S_EXT;
                        else begin
                            m_ofs[i] = m_ofs[i] - STEP;
                            if (m_ofs[i] <= 0) begin m_ofs[i] = 0; m_st[i] = S_IDLE; end
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic tick(input string name);
        out_t e, g;
        @(posedge clk);
        model_step();
        #1;
        g.draw = drawFlipper; g.rgb = RGB_flipper; g.hit = hitIndex; g.spd = speedX;
        e = exp_q.pop_front();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got draw=%0b rgb=%h hit=%0d spd=%0d, expected draw=%0b rgb=%h hit=%0d spd=%0d",
                     name, g.draw, g.rgb, g.hit, g.spd, e.draw, e.rgb, e.hit, e.spd);
        end
    endtask

    // One clock with model-derived expectation.
    task automatic cycle(input string name, input logic rst_n, input logic sof, input logic [NF-1:0] key,
                         input logic pse, input logic rl, input int px, input int py);
        @(negedge clk);
        resetN = rst_n; startOfFrame = sof; keyPressed = key; pause = pse; reset_level = rl;
        pixelX = 11'(px); pixelY = 11'(py);
        exp_q.push_back(model_out());
        tick(name);
    endtask

    task automatic frames(input string name, input int n, input logic [NF-1:0] key, input logic pse);
        for (int i = 0; i < n; i++) cycle(name, 1'b1, 1'b1, key, pse, 1'b0, 200, 444);
    endtask

    // Non-frame clock with an explicit hand-computed expectation.
    task automatic probe(input string name, input int px, input int py, input logic pse,
                         input logic d, input int h, input int s);
        out_t e;
        e = '0;
        if (d) begin e.draw = 1'b1; e.rgb = COLOR; e.hit = 3'(h); e.spd = s; end
        @(negedge clk);
        resetN = 1'b1; startOfFrame = 1'b0; reset_level = 1'b0; pause = pse;
        pixelX = 11'(px); pixelY = 11'(py);
        exp_q.push_back(e);
        tick(name);
    endtask

    task automatic level_reset();
        cycle("level_reset", 1'b1, 1'b0, '0, 1'b0, 1'b1, 0, 0);
    endtask

    vec_t vecs[12];
    int   spd_full0;
    int   spd_full1;

    initial begin
        for (int i = 0; i < NF; i++) begin m_st[i] = S_IDLE; m_ofs[i] = 0; m_cnt[i] = 0; end
`ifdef FLIPPER_BANK_HOLD_EN
        spd_full0 = 0;  spd_full1 = 0;
`else
        spd_full0 = -4; spd_full1 = 4;
`endif
        vecs[0]  = '{160, 440, 1'b1, 0};
        vecs[1]  = '{159, 440, 1'b0, 0};
        vecs[2]  = '{223, 447, 1'b1, 0};
        vecs[3]  = '{224, 444, 1'b0, 0};
        vecs[4]  = '{200, 439, 1'b0, 0};
        vecs[5]  = '{200, 448, 1'b0, 0};
        vecs[6]  = '{416, 444, 1'b1, 1};
        vecs[7]  = '{415, 444, 1'b0, 0};
        vecs[8]  = '{479, 441, 1'b1, 1};
        vecs[9]  = '{480, 444, 1'b0, 0};
        vecs[10] = '{0,   0,   1'b0, 0};
        vecs[11] = '{300, 444, 1'b0, 0};

        // Power-on reset with a pixel inside flipper 0.
        cycle("reset0", 1'b0, 1'b0, '0, 1'b0, 1'b0, 200, 444);
        cycle("reset1", 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 200, 444);

        // Rest-position coverage boundaries.
        for (int i = 0; i < 12; i++)
            probe($sformatf("rest_vec%0d", i), vecs[i].px, vecs[i].py, 1'b0, vecs[i].draw, vecs[i].hit, 0);

        // key[0] held: 8 frames reach full travel.
        frames("extend0", 8, 2'b01, 1'b0);
        probe("full0_edge",   192, 444, 1'b0, 1'b1, 0, spd_full0);
        probe("full0_before", 191, 444, 1'b0, 1'b0, 0, 0);
        probe("full0_inside", 200, 444, 1'b0, 1'b1, 0, spd_full0);
        probe("full0_right",  256, 444, 1'b0, 1'b0, 0, 0);
`ifdef FLIPPER_BANK_HOLD_EN
        frames("hold0", 29, 2'b01, 1'b0);
        probe("hold_last", 192, 444, 1'b0, 1'b1, 0, 0);
        frames("hold_exit", 1, 2'b01, 1'b0);
        probe("hold_retract", 192, 444, 1'b0, 1'b1, 0, -4);
`else
        frames("reextend", 1, 2'b01, 1'b0);
        probe("reextend_spd", 192, 444, 1'b0, 1'b1, 0, 4);
`endif
        level_reset();

        // Both to full travel, then reset_level overriding pause and startOfFrame.
        frames("extend_both", 8, 2'b11, 1'b0);
        probe("full1_edge",   384, 444, 1'b0, 1'b1, 1, spd_full1);
        probe("full1_before", 383, 444, 1'b0, 1'b0, 0, 0);
        cycle("rl_override", 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 0, 0);
        probe("rl_f0_rest", 160, 444, 1'b0, 1'b1, 0, 0);
        probe("rl_f0_left", 159, 444, 1'b0, 1'b0, 0, 0);
        probe("rl_f1_rest", 479, 444, 1'b0, 1'b1, 1, 0);
        probe("rl_f1_left", 415, 444, 1'b0, 1'b0, 0, 0);

        // key[1] 3 frames then released.
        frames("key1_press", 3, 2'b10, 1'b0);
        frames("key1_release", 1, 2'b00, 1'b0);
        probe("ret1_edge",   404, 444, 1'b0, 1'b1, 1, 4);
        probe("ret1_before", 403, 444, 1'b0, 1'b0, 0, 0);
        probe("ret1_right",  468, 444, 1'b0, 1'b0, 0, 0);
        frames("key1_retract", 1, 2'b00, 1'b0);
        probe("ret1_8_edge",   408, 444, 1'b0, 1'b1, 1, 4);
        probe("ret1_8_before", 407, 444, 1'b0, 1'b0, 0, 0);
        level_reset();

        // Pause during EXTEND.
        frames("pre_pause", 2, 2'b01, 1'b0);
        for (int i = 0; i < 5; i++) probe("pause_frame_out", 200, 444, 1'b1, 1'b1, 0, 0);
        frames("paused_frames", 5, 2'b01, 1'b1);
        probe("paused_edge",   168, 444, 1'b1, 1'b1, 0, 0);
        probe("paused_before", 167, 444, 1'b1, 1'b0, 0, 0);
        frames("resume", 1, 2'b01, 1'b0);
        probe("resume_edge",   172, 444, 1'b0, 1'b1, 0, 4);
        probe("resume_before", 171, 444, 1'b0, 1'b0, 0, 0);

        // resetN mid-EXTEND wins over a frame tick.
        cycle("rst_mid", 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 200, 444);
        probe("rst_f0_rest", 160, 444, 1'b0, 1'b1, 0, 0);
        probe("rst_f0_left", 159, 444, 1'b0, 1'b0, 0, 0);

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            cycle("random", ($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0),
                  NF'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0), ($urandom_range(0, 59) == 0),
                  $urandom_range(100, 520), $urandom_range(436, 450));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
